ex_mem_pipe_reg: RTL
====================

Name: ex_mem_pipe_reg

Overview:
Parametrised EX→MEM pipeline register with a valid/ready handshake, a one-entry skid buffer, flush/bubble insertion and a stall-cycle counter. It sits between the execute stage (ALU result, store data, destination register, funct3, RegWrite, MEM control) and the memory stage. It holds the stage under back-pressure without a combinational ready path from MEM to EX.

Parameters:
XLEN, 32, width of ALU result and store-data fields
REG_AW, 5, destination register address width
MEM_CTRL_W, 2, width of the MEM control field
CNT_W, 16, width of the saturating stall counter
ZERO_REG_SUPPRESS, 1, when 1, RegWrite is cleared at capture if the destination register is 0

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  EX presents a valid instruction
in_ready  out  1  register can accept this cycle
alu_in  in  XLEN  ALU result
rd2_in  in  XLEN  store data (register source 2)
a3_in  in  REG_AW  destination register
funct3_in  in  3  access size/sign
regwrite_in  in  1  RegWrite control
mem_ctrl_in  in  MEM_CTRL_W  MEM read/write control
flush  in  1  kill all held and incoming entries
out_valid  out  1  MEM-side entry valid
out_ready  in  1  MEM consumes this cycle
alu_out  out  XLEN  registered ALU result
rd2_out  out  XLEN  registered store data
a3_out  out  REG_AW  registered destination register
funct3_out  out  3  registered funct3
regwrite_out  out  1  RegWrite, gated by out_valid
mem_ctrl_out  out  MEM_CTRL_W  MEM control, gated by out_valid
stall_cnt  out  CNT_W  count of back-pressured cycles

Behaviour:
- Storage: main entry (drives outputs) plus one skid entry. Each entry has a valid bit and all payload fields.
- Clock and reset: single clock clk. Reset rst is synchronous and active-high, sampled on the rising edge.
- Reset values: both valid bits 0, all payload 0, stall_cnt 0. in_ready is 0 while rst=1. out_valid, regwrite_out and mem_ctrl_out are all 0.
- in_ready = ~rst & ~skid_valid. It is driven purely from state and never depends on out_ready.
- Accept = in_valid & in_ready. Drain = out_valid & out_ready.
- On accept:
  - If main is empty or drains this cycle, and skid is empty: load main.
  - Otherwise: load skid.
- On drain with skid valid: main ← skid, and skid becomes empty. Order is preserved; the skid never overtakes main.
- Drain, skid valid and accept cannot occur together, because in_ready=0 whenever skid is valid.
- Drain with skid empty and no accept: main becomes invalid.
- Latency and throughput: one cycle from accept to out_valid when out_ready stays high. Sustained throughput is one per cycle.
- Capture rule: when ZERO_REG_SUPPRESS=1 and a3_in==0, the stored regwrite is 0. All other fields are stored unchanged.
- Bubble gating:
  - regwrite_out = main_valid & main_regwrite.
  - mem_ctrl_out = main_valid ? main_mem_ctrl : 0.
  - Data outputs show stored values regardless of valid.
- Flush:
  - Clears both valid bits at the next edge and discards any input accepted in that cycle.
  - Payload registers are not required to clear.
  - Flush has priority over accept and drain. The next cycle has out_valid=0 and in_ready=1.
- rst has priority over flush.
- stall_cnt increments by 1 on every cycle with out_valid & ~out_ready. It saturates at 2^CNT_W−1 and clears only on rst.
- Reset mid-operation: all held entries are lost and no drain is signalled after the edge.

Decomposition:
- Shared package (pipeline-stage package): MEM control encodings (none / load / store) and the default XLEN/REG_AW constants.
- A packed EX/MEM payload struct, used by this block and the MEM stage.
- One natural sub-module, pipe_skid_buf: generic valid/ready two-entry skid buffer over a WIDTH-bit payload.
- ex_mem_pipe_reg wraps pipe_skid_buf and adds field packing, zero-register suppression, bubble gating and stall_cnt.

Test Plan:
- Reset then stream:
  - Stimulus: rst 2 cycles; send alu=0x00000010, a3=5, regwrite=1, mem_ctrl=01 with out_ready=1.
  - Required: out_valid=1 next cycle with those exact values; back-to-back packets appear every cycle in order.
- Back-pressure:
  - Stimulus: out_ready=0 with 3 packets (alu=1,2,3) offered.
  - Required: packets 1 and 2 are accepted (main and skid); in_ready=0 on the 3rd cycle; stall_cnt increments each held cycle.
  - Then out_ready=1: outputs 1, 2, 3 in order with no loss or duplicate.
- Flush with full skid:
  - Stimulus: main and skid both valid, flush=1 while in_valid=1.
  - Required: next cycle out_valid=0, regwrite_out=0, mem_ctrl_out=0, in_ready=1; the flushed-cycle input never appears.
- x0 suppression:
  - Stimulus: a3_in=0, regwrite_in=1 with ZERO_REG_SUPPRESS=1.
  - Required: regwrite_out=0 and a3_out=0.
  - With ZERO_REG_SUPPRESS=0: regwrite_out=1.
- Counter saturation:
  - Stimulus: CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles.
  - Required: stall_cnt stops at 15.
  - Then rst=1: stall_cnt=0 next cycle.
- Reset mid-stall:
  - Stimulus: both entries full, rst=1 for one cycle.
  - Required: out_valid=0, in_ready=0 during rst, in_ready=1 after; no stale packet emerges.

Source files
------------

// File: rtl/ex_mem_pipe_reg_pkg.sv
// ex_mem_pipe_reg_pkg: shared EX/MEM stage types, MEM control encodings and default widths
package ex_mem_pipe_reg_pkg;
  localparam int XLEN_D = 32;
  localparam int REG_AW_D = 5;
  typedef enum logic [1:0] {
    MC_NONE  = 2'b00,
    MC_LOAD  = 2'b01,
    MC_STORE = 2'b10
  } mem_ctrl_e;
  typedef struct packed {
    logic [XLEN_D-1:0]   alu;
    logic [XLEN_D-1:0]   rd2;
    logic [REG_AW_D-1:0] a3;
    logic [2:0]          funct3;
    logic                regwrite;
    mem_ctrl_e           mem_ctrl;
  } ex_mem_t;
endpackage

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: valid/ready register with one skid entry; ready depends only on state
module pipe_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  logic             accept, drain;
  assign in_ready = ~rst & ~skid_valid;
  assign accept = in_valid & in_ready;
  assign drain = out_valid & out_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_data   <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (drain & skid_valid) begin
      out_data   <= skid_data;
      skid_valid <= 1'b0;
    end else if (accept & (~out_valid | drain)) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end else if (drain) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/ex_mem_pipe_reg.sv
// ex_mem_pipe_reg: EX->MEM pipeline register with skid buffer, x0 suppression, bubble gating and stall counter
module ex_mem_pipe_reg
  import ex_mem_pipe_reg_pkg::*;
#(
  parameter int XLEN = XLEN_D,
  parameter int REG_AW = REG_AW_D,
  parameter int MEM_CTRL_W = 2,
  parameter int CNT_W = 16,
  parameter bit ZERO_REG_SUPPRESS = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       alu_in,
  input  logic [XLEN-1:0]       rd2_in,
  input  logic [REG_AW-1:0]     a3_in,
  input  logic [2:0]            funct3_in,
  input  logic                  regwrite_in,
  input  logic [MEM_CTRL_W-1:0] mem_ctrl_in,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       alu_out,
  output logic [XLEN-1:0]       rd2_out,
  output logic [REG_AW-1:0]     a3_out,
  output logic [2:0]            funct3_out,
  output logic                  regwrite_out,
  output logic [MEM_CTRL_W-1:0] mem_ctrl_out,
  output logic [CNT_W-1:0]      stall_cnt
);
  localparam int W = 2 * XLEN + REG_AW + 3 + 1 + MEM_CTRL_W;
  logic [W-1:0]          in_data, out_data;
  logic                  regwrite_cap, main_regwrite;
  logic [MEM_CTRL_W-1:0] main_mem_ctrl;
  // writes to x0 are architecturally void, so drop them before they enter the pipe
  assign regwrite_cap = regwrite_in & ~(ZERO_REG_SUPPRESS && a3_in == '0);
  assign in_data = {alu_in, rd2_in, a3_in, funct3_in, regwrite_cap, mem_ctrl_in};
  assign {alu_out, rd2_out, a3_out, funct3_out, main_regwrite, main_mem_ctrl} = out_data;
  pipe_skid_buf #(.WIDTH(W)) u_buf (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );
  assign regwrite_out = out_valid & main_regwrite;
  assign mem_ctrl_out = out_valid ? main_mem_ctrl : MEM_CTRL_W'(MC_NONE);
  always_ff @(posedge clk) begin
    if (rst) stall_cnt <= '0;
    else if (out_valid & ~out_ready & ~&stall_cnt) stall_cnt <= stall_cnt + 1'b1;
  end
endmodule
